// File: rtl/mc_control.sv
// Multi-cycle controller FSM for a MIPS-subset datapath: fetch/decode/execute/memory/writeback.
// Defining MC_CONTROL_BNE_EN adds bne support (opcode 000101 shares the BRANCH state with beq).
module mc_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [1:0]         zero,
  input  logic               mem_ready,
  output logic [2:0]         alu_ctrl,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEM_ADDR = STATE_W'(2),
    MEM_RD   = STATE_W'(3),
    MEM_WB   = STATE_W'(4),
    MEM_WR   = STATE_W'(5),
    EXEC     = STATE_W'(6),
    R_WB     = STATE_W'(7),
    BRANCH   = STATE_W'(8),
    JUMP     = STATE_W'(9),
    ADDI_EX  = STATE_W'(10),
    ADDI_WB  = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b111;

  state_t state_q;
  state_t state_d;
  logic   illegal_q;
  logic   set_illegal;
  logic   branch_take;
  logic   unused_zero_hi;

  // Only bit 0 of the ALU status carries the zero result.
  assign unused_zero_hi = zero[1];

`ifdef MC_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE = 6'b000101;
  logic is_bne_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_bne_q <= 1'b0;
    end else if (state_q == DECODE) begin
      is_bne_q <= (opcode == OP_BNE);
    end
  end

  assign branch_take = zero[0] ^ is_bne_q;
`else
  assign branch_take = zero[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q & ~rst;

  // Reset forces every enable low combinationally so an aborted op cannot write.
  always_comb begin
    state_d     = FETCH;
    set_illegal = 1'b0;
    alu_ctrl    = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          state_d   = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE:     state_d = EXEC;
            OP_LW, OP_SW: state_d = MEM_ADDR;
            OP_BEQ:       state_d = BRANCH;
`ifdef MC_CONTROL_BNE_EN
            OP_BNE:       state_d = BRANCH;
`endif
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = ADDI_EX;
            default: begin
              state_d     = FETCH;
              set_illegal = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          state_d  = mem_ready ? MEM_WB : MEM_RD;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          state_d   = mem_ready ? FETCH : MEM_WR;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          state_d   = R_WB;
          case (funct)
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: begin
              alu_ctrl    = ALU_NOT;
              set_illegal = 1'b1;
              state_d     = FETCH;
            end
          endcase
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_source = 2'b01;
          pc_en     = branch_take;
        end
        JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
        end
        ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = ADDI_WB;
        end
        ADDI_WB: begin
          reg_write = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
